and_run_detector: RTL and testbench

Downstream consumer of the registered AND/flip-flop stage. Samples that stage's output `z` on cycles where the stage's `enable` is high. Detects runs of consecutive 1s of length RUN_LEN and counts detected runs.
Provides run status and event counters to the checker and debug logic that sit after the AND stage.

---
 rtl/and_run_detector.sv | 124 ++++++++++++
 tb/tb_and_run_detector.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/and_run_detector.sv
// Counts consecutive qualified 1-samples of the AND stage output and pulses hit once per run of RUN_LEN.
// Optional sticky hit flag enabled by defining AND_RUN_STICKY_EN; otherwise hit_sticky is tied low.
module and_run_detector #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             z_in,
  input  logic             clr,
  output logic [CNT_W-1:0] run_len,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [1:0]       state,
  output logic             hit_sticky
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HIT    = 2'd2,
    S_UNUSED = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] run_inc;

  assign run_inc = (run_len_q == CNT_MAX) ? CNT_MAX : run_len_q + ONE_C;

  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    hit_cnt_d = hit_cnt_q;
    hit_d     = 1'b0;
    if (clr) begin
      state_d   = S_IDLE;
      run_len_d = '0;
      hit_cnt_d = '0;
    end else if (state_q == S_UNUSED) begin
      // Recover from the unused encoding even while no sample is qualified.
      state_d   = S_IDLE;
      run_len_d = '0;
    end else if (valid) begin
      case (state_q)
        S_IDLE: begin
          if (z_in) begin
            state_d   = S_RUN;
            run_len_d = ONE_C;
          end else begin
            run_len_d = '0;
          end
        end
        S_RUN: begin
          if (z_in) begin
            run_len_d = run_inc;
            if (run_inc == RUN_LEN_C) begin
              state_d = S_HIT;
              hit_d   = 1'b1;
              if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + ONE_C;
            end
          end else begin
            state_d   = S_IDLE;
            run_len_d = '0;
          end
        end
        S_HIT: begin
          if (z_in) begin
            run_len_d = run_inc;
          end else begin
            state_d   = S_IDLE;
            run_len_d = '0;
          end
        end
        default: begin
          state_d   = S_IDLE;
          run_len_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      run_len_q <= '0;
      hit_cnt_q <= '0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      hit_cnt_q <= hit_cnt_d;
      hit_q     <= hit_d;
    end
  end

`ifdef AND_RUN_STICKY_EN
  logic sticky_q, sticky_d;

  assign sticky_d = clr ? 1'b0 : (sticky_q | hit_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign hit_sticky = sticky_q;
`else
  assign hit_sticky = 1'b0;
`endif

  assign state   = state_q;
  assign run_len = run_len_q;
  assign hit_cnt = hit_cnt_q;
  assign hit     = hit_q;

endmodule

// File: tb/tb_and_run_detector.sv
// Directed bench for and_run_detector: main instance RUN_LEN=3/CNT_W=8, plus a CNT_W=2 instance for hit_cnt saturation.
module tb_and_run_detector;

`ifdef AND_RUN_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0, z_in = 1'b0, clr = 1'b0;
  logic [7:0] run_len, hit_cnt;
  logic       hit, hit_sticky;
  logic [1:0] state;

  logic       valid2 = 1'b0, z2 = 1'b0, clr2 = 1'b0;
  logic [1:0] run_len2, hit_cnt2, state2;
  logic       hit2, hit_sticky2;

  int ncmp = 0;
  int nerr = 0;
  int hits;

  always #5 clk = ~clk;

  and_run_detector #(.RUN_LEN(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .z_in(z_in), .clr(clr),
    .run_len(run_len), .hit(hit), .hit_cnt(hit_cnt), .state(state), .hit_sticky(hit_sticky)
  );

  and_run_detector #(.RUN_LEN(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid(valid2), .z_in(z2), .clr(clr2),
    .run_len(run_len2), .hit(hit2), .hit_cnt(hit_cnt2), .state(state2), .hit_sticky(hit_sticky2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] st, input logic [7:0] rl,
                     input logic h, input logic [7:0] cnt, input logic stk);
    check({tag, ".state"},   32'(state),      32'(st));
    check({tag, ".run_len"}, 32'(run_len),    32'(rl));
    check({tag, ".hit"},     32'(hit),        32'(h));
    check({tag, ".hit_cnt"}, 32'(hit_cnt),    32'(cnt));
    check({tag, ".sticky"},  32'(hit_sticky), 32'(stk & STK));
  endtask

  task automatic step(input logic v, input logic z, input logic c);
    valid = v; z_in = z; clr = c;
    @(posedge clk);
    #1;
    valid = 1'b0; z_in = 1'b0; clr = 1'b0;
  endtask

  task automatic step2(input logic v, input logic z);
    valid2 = v; z2 = z;
    @(posedge clk);
    #1;
    valid2 = 1'b0; z2 = 1'b0;
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 2'd0, 8'd0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;

    // basic run of three
    step(1, 1, 0); chk("t1.s1", 2'd1, 8'd1, 1'b0, 8'd0, 1'b0);
    step(1, 1, 0); chk("t1.s2", 2'd1, 8'd2, 1'b0, 8'd0, 1'b0);
    step(1, 1, 0); chk("t1.s3", 2'd2, 8'd3, 1'b1, 8'd1, 1'b1);
    step(0, 0, 0); chk("t1.drop", 2'd2, 8'd3, 1'b0, 8'd1, 1'b1);

    // broken run 1,1,0,1,1,1
    step(0, 0, 1); chk("t2.clr", 2'd0, 8'd0, 1'b0, 8'd0, 1'b0);
    step(1, 1, 0);
    step(1, 1, 0); chk("t2.pair", 2'd1, 8'd2, 1'b0, 8'd0, 1'b0);
    step(1, 0, 0); chk("t2.zero", 2'd0, 8'd0, 1'b0, 8'd0, 1'b0);
    step(1, 1, 0);
    step(1, 1, 0); chk("t2.pair2", 2'd1, 8'd2, 1'b0, 8'd0, 1'b0);
    step(1, 1, 0); chk("t2.hit", 2'd2, 8'd3, 1'b1, 8'd1, 1'b1);

    // clr after a registered hit
    step(0, 0, 0); chk("t3.pre", 2'd2, 8'd3, 1'b0, 8'd1, 1'b1);
    step(1, 1, 1); chk("t3.clr", 2'd0, 8'd0, 1'b0, 8'd0, 1'b0);

    // gap in valid does not break a run
    step(1, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0); chk("t4.gap", 2'd1, 8'd2, 1'b0, 8'd0, 1'b0);
    end
    step(1, 1, 0); chk("t4.hit", 2'd2, 8'd3, 1'b1, 8'd1, 1'b1);

    // ten 1s -> one hit
    step(0, 0, 1);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0);
      if (hit) hits++;
      check("t5.hit_i", 32'(hit), (i == 2) ? 32'd1 : 32'd0);
    end
    chk("t5.end", 2'd2, 8'd10, 1'b0, 8'd1, 1'b1);
    check("t5.pulses", 32'(hits), 32'd1);

    // clr on the same edge as a would-be hit
    step(0, 0, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1); chk("t6.clrwins", 2'd0, 8'd0, 1'b0, 8'd0, 1'b0);

    // asynchronous reset mid-run
    step(1, 1, 0);
    step(1, 1, 0); chk("t7.pre", 2'd1, 8'd2, 1'b0, 8'd0, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk("t7.async", 2'd0, 8'd0, 1'b0, 8'd0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t7.post", 2'd0, 8'd0, 1'b0, 8'd0, 1'b0);

    // CNT_W=2: four runs of three, hit_cnt saturates at 3
    hits = 0;
    for (int r = 0; r < 4; r++) begin
      step2(1, 1);
      step2(1, 1);
      step2(1, 1);
      if (hit2) hits++;
      check("t8.hit", 32'(hit2), 32'd1);
      check("t8.cnt", 32'(hit_cnt2), (r < 3) ? 32'(r + 1) : 32'd3);
      step2(1, 0);
      check("t8.idle", 32'(state2), 32'd0);
    end
    check("t8.pulses", 32'(hits), 32'd4);
    check("t8.final", 32'(hit_cnt2), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
